// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
// Optional memory-wait watchdog is built when CTRL_MEM_TIMEOUT_EN is defined.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BAD
  } cls_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t state_q, state_d;
  cls_t   cls_q, cls_dec;
  logic   illegal_q, illegal_set;
  logic   timeout_hit;

  always_comb begin
    case (opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_IALU;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      7'b1101111: cls_dec = C_JAL;
      7'b1100111: cls_dec = C_JALR;
      default:    cls_dec = C_BAD;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    rf_we       = 1'b0;
    wb_sel      = 2'b00;
    alu_src     = 1'b0;
    alu_op      = 2'b00;

    // MEM keeps the EXEC operand select so the address stays stable
    if (state_q == S_EXEC || state_q == S_MEM) begin
      case (cls_q)
        C_R:      begin alu_src = 1'b0; alu_op = 2'b10; end
        C_IALU:   begin alu_src = 1'b1; alu_op = 2'b11; end
        C_BRANCH: begin alu_src = 1'b0; alu_op = 2'b01; end
        default:  begin alu_src = 1'b1; alu_op = 2'b00; end
      endcase
    end

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        if (cls_dec == C_BAD) begin
          state_d     = S_HALT;
          illegal_set = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        case (cls_q)
          C_LOAD:        wb_sel = 2'b01;
          C_JAL, C_JALR: wb_sel = 2'b10;
          C_LUI:         wb_sel = 2'b11;
          default:       wb_sel = 2'b00;
        endcase
        case (cls_q)
          C_JAL:   pc_sel = 2'b01;
          C_JALR:  pc_sel = 2'b10;
          default: pc_sel = 2'b00;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST;
      cls_q     <= C_R;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        waiting;
  logic        timeout_q;

  assign waiting = (state_q == S_FETCH && !imem_ready) ||
                   (state_q == S_MEM && !dmem_ready);
  // this wait cycle is the one that brings the count up to the limit
  assign timeout_hit = waiting && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) wait_cnt <= 16'd0;
      else if (waiting)       wait_cnt <= wait_cnt + 16'd1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a per-instruction trace model builds the expected
// output sequence from phase rules; one compare process checks every cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_src, illegal, mem_timeout;
  logic [1:0] pc_sel, wb_sel, alu_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
    .mem_timeout(mem_timeout), .state(state)
  );

  typedef struct packed {
    logic [2:0] state;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic rf_we;
    logic [1:0] wb_sel;
    logic alu_src;
    logic [1:0] alu_op;
    logic illegal, mem_timeout;
  } outs_t;

  typedef struct packed {
    logic rst, ir, dr;
    logic [6:0] op;
    logic bt, chk;
    outs_t exp;
  } ent_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
    OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  ent_t  q[$];
  ent_t  cur = '0;
  int    n_chk = 0, n_pass = 0, cyc = 0;
  logic  m_ill = 1'b0, m_to = 1'b0;
  logic [6:0] g_op = 7'd0;
  logic  g_bt = 1'b0;
  outs_t got;

  assign got = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                wb_sel, alu_src, alu_op, illegal, mem_timeout};

  function automatic outs_t base(input logic [2:0] st);
    outs_t o = '0;
    o.state = st;
    o.illegal = m_ill;
    o.mem_timeout = m_to;
    return o;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // ready inputs not being waited on are driven high to show they are ignored
  task automatic push(input logic ir, input logic dr, input outs_t o);
    ent_t e;
    e.rst = 1'b0; e.ir = ir; e.dr = dr; e.op = g_op; e.bt = g_bt; e.chk = 1'b1; e.exp = o;
    q.push_back(e);
  endtask

  task automatic reset_after();
    ent_t e;
    e = q.pop_back();
    e.rst = 1'b1;
    q.push_back(e);
    m_ill = 1'b0;
    m_to  = 1'b0;
    push(1'b1, 1'b1, base(3'd0));
  endtask

  task automatic ph_fetch(input int iw);
    outs_t o;
    for (int i = 0; i < iw; i++) begin
      o = base(3'd1); o.imem_req = 1'b1;
      push(1'b0, 1'b1, o);
    end
    o = base(3'd1); o.imem_req = 1'b1; o.ir_we = 1'b1;
    push(1'b1, 1'b1, o);
  endtask

  task automatic ph_mem_wait(input int dw);
    outs_t o;
    for (int i = 0; i < dw; i++) begin
      o = base(3'd4); o.dmem_req = 1'b1; o.dmem_we = (g_op == OP_ST); o.alu_src = 1'b1;
      push(1'b1, 1'b0, o);
    end
  endtask

  // Expected trace of one instruction from fetch to the cycle before the next fetch.
  task automatic run(input logic [6:0] op, input int iw, input int dw, input logic bt,
                     output int len);
    outs_t o;
    int sz0 = q.size();
    g_op = op; g_bt = bt;
    ph_fetch(iw);
    push(1'b1, 1'b1, base(3'd2));
    if (!legal(op)) begin
      m_ill = 1'b1;
      len = q.size() - sz0;
      return;
    end
    o = base(3'd3);
    case (op)
      OP_R:    o.alu_op = 2'b10;
      OP_I:    begin o.alu_src = 1'b1; o.alu_op = 2'b11; end
      OP_BR:   begin o.alu_op = 2'b01; o.pc_we = 1'b1; o.pc_sel = bt ? 2'b01 : 2'b00; end
      default: o.alu_src = 1'b1;
    endcase
    push(1'b1, 1'b1, o);
    if (op == OP_LD || op == OP_ST) begin
      ph_mem_wait(dw);
      o = base(3'd4); o.dmem_req = 1'b1; o.dmem_we = (op == OP_ST); o.alu_src = 1'b1;
      o.pc_we = (op == OP_ST);
      push(1'b1, 1'b1, o);
    end
    if (op != OP_BR && op != OP_ST) begin
      o = base(3'd5); o.rf_we = 1'b1; o.pc_we = 1'b1;
      o.wb_sel = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 :
                 (op == OP_LUI) ? 2'd3 : 2'd0;
      o.pc_sel = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
      push(1'b1, 1'b1, o);
    end
    len = q.size() - sz0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (cur.chk) begin
      n_chk++;
      if (got == cur.exp && !(imem_req && dmem_req)) n_pass++;
      else $display("FAIL cycle %0d outputs: got state=%0d bits=%h, want state=%0d bits=%h",
                    cyc, got.state, got, cur.exp.state, cur.exp);
    end
  end

  initial begin
    ent_t e0;
    int   len;
    outs_t o;
    e0 = '0;
    q.push_back(e0);
    reset_after();

    run(OP_R, 0, 0, 1'b0, len);   check("add_cycles", len, 4);
    run(OP_LD, 0, 3, 1'b0, len);  check("lw_wait3_cycles", len, 8);
    run(OP_BR, 0, 0, 1'b1, len);  check("beq_taken_cycles", len, 3);
    run(OP_BR, 0, 0, 1'b0, len);  check("beq_not_taken_cycles", len, 3);
    run(OP_JALR, 0, 0, 1'b0, len); check("jalr_cycles", len, 4);
    run(OP_ST, 2, 1, 1'b0, len);  check("sw_waits_cycles", len, 7);
    run(OP_I, 1, 0, 1'b1, len);
    run(OP_LUI, 0, 0, 1'b0, len);
    run(OP_AUI, 0, 0, 1'b0, len);
    run(OP_JAL, 3, 0, 1'b0, len); check("jal_wait3_cycles", len, 7);

    // reset while a load is waiting in MEM
    g_op = OP_LD; g_bt = 1'b0;
    ph_fetch(0);
    push(1'b1, 1'b1, base(3'd2));
    o = base(3'd3); o.alu_src = 1'b1;
    push(1'b1, 1'b1, o);
    ph_mem_wait(3);
    reset_after();

    run(7'b0000000, 0, 0, 1'b0, len); check("illegal_cycles", len, 2);
    for (int i = 0; i < 20; i++) push(1'b1, 1'b1, base(3'd7));
    reset_after();

    g_op = OP_R;
`ifdef CTRL_MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      o = base(3'd1); o.imem_req = 1'b1;
      push(1'b0, 1'b1, o);
    end
    m_to = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, 1'b1, base(3'd7));
`else
    for (int i = 0; i < 30; i++) begin
      o = base(3'd1); o.imem_req = 1'b1;
      push(1'b0, 1'b1, o);
    end
`endif
    reset_after();
    run(OP_R, 0, 0, 1'b0, len);

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst        = q[i].rst;
      imem_ready = q[i].ir;
      dmem_ready = q[i].dr;
      opcode     = q[i].op;
      br_taken   = q[i].bt;
      cur        = q[i];
    end
    @(posedge clk);
    #1;
    cur.chk = 1'b0;
    #10;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
